mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL provide clk  input  1  rising-edge clock.
REQ-002 SHALL provide reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide MemRead_MEM  input  1  load request this cycle.
REQ-004 SHALL provide MemWrite_MEM  input  1  store request this cycle.
REQ-005 SHALL provide ALUOut_MEM  input  32  byte address or pass-through ALU result.
REQ-006 SHALL provide WriteData_MEM  input  32  store data.
REQ-007 SHALL provide Rw_MEM  input  5  destination register.
REQ-008 SHALL provide MemtoReg_MEM, RegWrite_MEM  input  1 each  writeback controls.
REQ-009 SHALL provide WBData_WB  output  32  registered writeback data.
REQ-010 SHALL provide Rw_WB  output  5  registered destination register.
REQ-011 SHALL provide RegWrite_WB  output  1  registered write enable.
REQ-012 SHALL provide leds  output  8  LED register.
REQ-013 SHALL provide irq  output  1  timer interrupt, level.

Function
REQ-014 SHALL implement a data RAM of 256x32 words at 0x00000000-0x000003FF, indexed by ALUOut_MEM[9:2], with address bits [1:0] ignored.
REQ-015 SHALL map the MMIO registers TH 0x40000000, TL 0x40000004, TCON 0x40000008 (bits [2:0]: enable, irq-enable, status) and LED 0x4000000C (bits [7:0]).
REQ-016 SHALL decode reads combinationally and register them into WBData_WB at the next edge, giving 1-cycle latency from the MEM stage to the WB stage.
REQ-017 SHALL select WBData_WB as the read data when MemtoReg_MEM=1 and as ALUOut_MEM otherwise.
REQ-018 SHALL commit stores at the rising edge when MemWrite_MEM=1.
REQ-019 SHALL handle a simultaneous MemRead_MEM and MemWrite_MEM at the same address by returning the old data.
REQ-020 SHALL return 0 for reads of unmapped addresses and SHALL ignore writes to unmapped addresses.
REQ-021 SHALL increment TL by 1 every cycle while TCON[0]=1.
REQ-022 SHALL, when TL=0xFFFFFFFF and TCON[0]=1, load TL with TH on the next edge (wrap) and set TCON[2] if TCON[1]=1.
REQ-023 SHALL give a CPU write to TL priority over the increment or reload in the same cycle.
REQ-024 SHALL, for a CPU write to TCON in the same cycle as a wrap event, take bits [1:0] from the write and set bit [2] (set dominates clear).
REQ-025 SHALL drive irq = TCON[1] & TCON[2], combinationally from the registers.
REQ-026 SHALL propagate Rw_MEM and RegWrite_MEM to Rw_WB and RegWrite_WB with 1-cycle latency.

Reset
REQ-027 SHALL clear WBData_WB, Rw_WB, RegWrite_WB, leds, TH, TL and TCON to 0 asynchronously on reset.
REQ-028 SHALL leave RAM contents undefined after reset and SHALL NOT require the RAM to be cleared.
REQ-029 SHALL block any store in flight at reset assertion, so no RAM write occurs while reset=1.

Configuration
REQ-030 SHALL, with MEM_TIMER_EN defined, implement TH, TL, TCON and irq as specified above.
REQ-031 SHALL, without MEM_TIMER_EN, omit the timer logic, read 0 at 0x40000000-0x40000008, ignore writes there, and tie irq to 0.
REQ-032 SHALL keep the LED register and data RAM present in both configurations.

Structure
REQ-033 SHALL define the address map constants (RAM_BASE, RAM_WORDS, TH_ADDR, TL_ADDR, TCON_ADDR, LED_ADDR) and the TCON bit indices in the shared package mips_pkg.
REQ-034 SHALL place the timer (TH, TL, TCON, wrap, irq) in one sub-module timer_mmio, instantiated only under MEM_TIMER_EN.
REQ-035 SHALL keep the RAM, the address decode and the MEM/WB output register in mem_stage.

Verification
REQ-036 SHALL cover: store 0xDEADBEEF to 0x00000010, then load 0x00000013 with MemtoReg=1 -> WBData_WB=0xDEADBEEF one cycle after the load.
REQ-037 SHALL cover: MemtoReg=0, ALUOut=0x12345678, Rw=5, RegWrite=1 -> next edge WBData_WB=0x12345678, Rw_WB=5, RegWrite_WB=1.
REQ-038 SHALL cover: TH=0xFFFFFFF0, TL=0xFFFFFFFE, TCON=3 -> after 2 cycles TL=0xFFFFFFF0, irq=1; then write TCON=3 -> irq stays 1 if a wrap coincides, else 0.
REQ-039 SHALL cover: write TL=0x100 in the same cycle as a wrap -> TL=0x100, TCON[2] set.
REQ-040 SHALL cover: load from 0x80000000 -> WBData_WB=0; store to 0x80000000 -> RAM and MMIO registers unchanged.
REQ-041 SHALL cover: assert reset mid-store with leds=0xAA -> all outputs 0 immediately, irq=0; build without MEM_TIMER_EN -> TL reads 0.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared address map, TCON bit indices and address decode for the MEM stage
//
// Contents:
//   RAM_BASE, RAM_WORDS, RAM_AW           data RAM placement and index width
//   TH_ADDR, TL_ADDR, TCON_ADDR, LED_ADDR MMIO register addresses
//   TCON_EN, TCON_IE, TCON_ST             TCON bit positions
//   region_e / decode_region()            byte address -> target region
package mips_pkg;

  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam int          RAM_WORDS = 256;
  localparam int          RAM_AW    = 8;

  localparam logic [31:0] TH_ADDR   = 32'h4000_0000;
  localparam logic [31:0] TL_ADDR   = 32'h4000_0004;
  localparam logic [31:0] TCON_ADDR = 32'h4000_0008;
  localparam logic [31:0] LED_ADDR  = 32'h4000_000C;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  typedef enum logic [2:0] {
    REGION_NONE = 3'd0,
    REGION_RAM  = 3'd1,
    REGION_TH   = 3'd2,
    REGION_TL   = 3'd3,
    REGION_TCON = 3'd4,
    REGION_LED  = 3'd5
  } region_e;

  // Byte-lane bits [1:0] never take part in the decode, so every byte
  // address inside a word selects the same register or RAM word.
  function automatic region_e decode_region(input logic [31:0] addr);
    region_e r;
    r = REGION_NONE;
    if (addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2])
      r = REGION_RAM;
    else if (addr[31:2] == TH_ADDR[31:2])
      r = REGION_TH;
    else if (addr[31:2] == TL_ADDR[31:2])
      r = REGION_TL;
    else if (addr[31:2] == TCON_ADDR[31:2])
      r = REGION_TCON;
    else if (addr[31:2] == LED_ADDR[31:2])
      r = REGION_LED;
    return r;
  endfunction

endpackage

// File: rtl/timer_mmio.sv
// rtl/timer_mmio.sv - TH/TL/TCON free-running timer with reload-on-wrap and level interrupt
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   i_th_we         CPU write strobe for TH
//   i_tl_we         CPU write strobe for TL
//   i_tcon_we       CPU write strobe for TCON
//   i_wdata         CPU write data
//   o_th, o_tl      current TH / TL values
//   o_tcon          current TCON[2:0] (enable, irq-enable, status)
//   o_irq           TCON irq-enable & status, straight from the registers
module timer_mmio
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_th_we,
  input  logic        i_tl_we,
  input  logic        i_tcon_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_th,
  output logic [31:0] o_tl,
  output logic [2:0]  o_tcon,
  output logic        o_irq
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;

  logic        w_wrap;
  logic        w_set_status;
  logic [2:0]  w_tcon_next;

  assign w_wrap       = r_tcon[TCON_EN] & (r_tl == 32'hFFFF_FFFF);
  assign w_set_status = w_wrap & r_tcon[TCON_IE];

  // A CPU write supplies the control bits, but a wrap in the same cycle
  // still raises status so the event is never lost.
  always_comb begin
    w_tcon_next = r_tcon;
    if (i_tcon_we)
      w_tcon_next = i_wdata[2:0];
    if (w_set_status)
      w_tcon_next[TCON_ST] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_th   <= 32'h0;
      r_tl   <= 32'h0;
      r_tcon <= 3'b000;
    end else begin
      if (i_th_we)
        r_th <= i_wdata;

      // CPU write beats the reload, which beats the plain increment.
      if (i_tl_we)
        r_tl <= i_wdata;
      else if (w_wrap)
        r_tl <= r_th;
      else if (r_tcon[TCON_EN])
        r_tl <= r_tl + 32'd1;

      r_tcon <= w_tcon_next;
    end
  end

  assign o_th   = r_th;
  assign o_tl   = r_tl;
  assign o_tcon = r_tcon;
  assign o_irq  = r_tcon[TCON_IE] & r_tcon[TCON_ST];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: data RAM, MMIO decode (LED, optional timer) and MEM/WB register
//
// Build option: MEM_TIMER_EN adds the TH/TL/TCON timer and irq; without it
// the timer addresses read 0, ignore writes, and irq is tied low.
//
// Ports:
//   clk, reset                   rising-edge clock, asynchronous active-high reset
//   MemRead_MEM, MemWrite_MEM    load / store request this cycle
//   ALUOut_MEM                   byte address, or ALU result passed to WB
//   WriteData_MEM                store data
//   Rw_MEM                       destination register
//   MemtoReg_MEM, RegWrite_MEM   writeback controls
//   WBData_WB, Rw_WB, RegWrite_WB registered writeback outputs
//   leds                         LED register
//   irq                          timer interrupt (level)
module mem_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic [31:0] ALUOut_MEM,
  input  logic [31:0] WriteData_MEM,
  input  logic [4:0]  Rw_MEM,
  input  logic        MemtoReg_MEM,
  input  logic        RegWrite_MEM,
  output logic [31:0] WBData_WB,
  output logic [4:0]  Rw_WB,
  output logic        RegWrite_WB,
  output logic [7:0]  leds,
  output logic        irq
);

  region_e            w_region;
  logic [RAM_AW-1:0]  w_ram_idx;
  logic               w_store;
  logic [31:0]        w_rdata_dec;
  logic [31:0]        w_rdata;
  logic [31:0]        w_wb_next;
  logic [31:0]        w_th;
  logic [31:0]        w_tl;
  logic [2:0]         w_tcon;

  logic [31:0]        r_ram [RAM_WORDS];
  logic [7:0]         r_leds;
  logic [31:0]        r_wbdata;
  logic [4:0]         r_rw;
  logic               r_regwrite;

  assign w_region  = decode_region(ALUOut_MEM);
  assign w_ram_idx = ALUOut_MEM[RAM_AW+1:2];

  // Stores are masked by reset itself so a store caught by reset assertion
  // cannot land in the RAM, which has no reset of its own.
  assign w_store = MemWrite_MEM & ~reset;

  always_ff @(posedge clk) begin
    if (w_store && (w_region == REGION_RAM))
      r_ram[w_ram_idx] <= WriteData_MEM;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_leds <= 8'h00;
    else if (w_store && (w_region == REGION_LED))
      r_leds <= WriteData_MEM[7:0];
  end

`ifdef MEM_TIMER_EN
  logic w_irq;

  timer_mmio u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_th_we   (w_store && (w_region == REGION_TH)),
    .i_tl_we   (w_store && (w_region == REGION_TL)),
    .i_tcon_we (w_store && (w_region == REGION_TCON)),
    .i_wdata   (WriteData_MEM),
    .o_th      (w_th),
    .o_tl      (w_tl),
    .o_tcon    (w_tcon),
    .o_irq     (w_irq)
  );

  assign irq = w_irq;
`else
  assign w_th   = 32'h0;
  assign w_tl   = 32'h0;
  assign w_tcon = 3'b000;
  assign irq    = 1'b0;
`endif

  // Reads see pre-edge state, so a load and store to the same word in one
  // cycle return the old contents.
  always_comb begin
    w_rdata_dec = 32'h0;
    case (w_region)
      REGION_RAM:  w_rdata_dec = r_ram[w_ram_idx];
      REGION_TH:   w_rdata_dec = w_th;
      REGION_TL:   w_rdata_dec = w_tl;
      REGION_TCON: w_rdata_dec = {29'h0, w_tcon};
      REGION_LED:  w_rdata_dec = {24'h0, r_leds};
      default:     w_rdata_dec = 32'h0;
    endcase
  end

  assign w_rdata   = MemRead_MEM ? w_rdata_dec : 32'h0;
  assign w_wb_next = MemtoReg_MEM ? w_rdata : ALUOut_MEM;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wbdata   <= 32'h0;
      r_rw       <= 5'd0;
      r_regwrite <= 1'b0;
    end else begin
      r_wbdata   <= w_wb_next;
      r_rw       <= Rw_MEM;
      r_regwrite <= RegWrite_MEM;
    end
  end

  assign WBData_WB   = r_wbdata;
  assign Rw_WB       = r_rw;
  assign RegWrite_WB = r_regwrite;
  assign leds        = r_leds;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage (timer tests only when MEM_TIMER_EN is defined)
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead_MEM, MemWrite_MEM, MemtoReg_MEM, RegWrite_MEM;
  logic [31:0] ALUOut_MEM, WriteData_MEM;
  logic [4:0]  Rw_MEM;
  logic [31:0] WBData_WB;
  logic [4:0]  Rw_WB;
  logic        RegWrite_WB;
  logic [7:0]  leds;
  logic        irq;

  int errors = 0;
  int checks = 0;
  logic [31:0] mem_m [256];

  mem_stage dut (
    .clk           (clk),
    .reset         (reset),
    .MemRead_MEM   (MemRead_MEM),
    .MemWrite_MEM  (MemWrite_MEM),
    .ALUOut_MEM    (ALUOut_MEM),
    .WriteData_MEM (WriteData_MEM),
    .Rw_MEM        (Rw_MEM),
    .MemtoReg_MEM  (MemtoReg_MEM),
    .RegWrite_MEM  (RegWrite_MEM),
    .WBData_WB     (WBData_WB),
    .Rw_WB         (Rw_WB),
    .RegWrite_WB   (RegWrite_WB),
    .leds          (leds),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic set_idle();
    MemRead_MEM = 0; MemWrite_MEM = 0; MemtoReg_MEM = 0; RegWrite_MEM = 0;
    ALUOut_MEM = 0; WriteData_MEM = 0; Rw_MEM = 0;
  endtask

  // One MEM-stage cycle; returns 1 time unit after the edge with inputs idle.
  task automatic drive(input logic mr, input logic mw, input logic mtr, input logic regw,
                       input logic [4:0] rw, input logic [31:0] addr, input logic [31:0] wd);
    MemRead_MEM = mr; MemWrite_MEM = mw; MemtoReg_MEM = mtr; RegWrite_MEM = regw;
    Rw_MEM = rw; ALUOut_MEM = addr; WriteData_MEM = wd;
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic st(input logic [31:0] addr, input logic [31:0] wd);
    drive(0, 1, 0, 0, 5'd0, addr, wd);
  endtask

  task automatic ld(input logic [31:0] addr);
    drive(1, 0, 1, 1, 5'd1, addr, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    checks++; if (WBData_WB !== 32'h0) begin errors++; $display("FAIL rst_wbdata got=%h exp=0", WBData_WB); end
    checks++; if (Rw_WB !== 5'd0) begin errors++; $display("FAIL rst_rw got=%h exp=0", Rw_WB); end
    checks++; if (RegWrite_WB !== 1'b0) begin errors++; $display("FAIL rst_regwrite got=%b exp=0", RegWrite_WB); end
    checks++; if (leds !== 8'h00) begin errors++; $display("FAIL rst_leds got=%h exp=0", leds); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b exp=0", irq); end
  endtask

  task automatic test_store_load();
    st(32'h0000_0010, 32'hDEAD_BEEF);
    mem_m[4] = 32'hDEAD_BEEF;
    drive(1, 0, 1, 1, 5'd7, 32'h0000_0013, 32'h0);
    checks++; if (WBData_WB !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_load got=%h exp=deadbeef", WBData_WB); end
    checks++; if (Rw_WB !== 5'd7) begin errors++; $display("FAIL store_load_rw got=%0d exp=7", Rw_WB); end
    checks++; if (RegWrite_WB !== 1'b1) begin errors++; $display("FAIL store_load_regwrite got=%b exp=1", RegWrite_WB); end
  endtask

  task automatic test_passthrough();
    drive(0, 0, 0, 1, 5'd5, 32'h1234_5678, 32'h0);
    checks++; if (WBData_WB !== 32'h1234_5678) begin errors++; $display("FAIL pass_data got=%h exp=12345678", WBData_WB); end
    checks++; if (Rw_WB !== 5'd5) begin errors++; $display("FAIL pass_rw got=%0d exp=5", Rw_WB); end
    checks++; if (RegWrite_WB !== 1'b1) begin errors++; $display("FAIL pass_regwrite got=%b exp=1", RegWrite_WB); end
  endtask

  task automatic test_same_addr_rw();
    st(32'h0000_0020, 32'h1111_2222);
    drive(1, 1, 1, 1, 5'd9, 32'h0000_0020, 32'h3333_4444);
    checks++; if (WBData_WB !== 32'h1111_2222) begin errors++; $display("FAIL rw_same_old got=%h exp=11112222", WBData_WB); end
    ld(32'h0000_0022);
    checks++; if (WBData_WB !== 32'h3333_4444) begin errors++; $display("FAIL rw_same_new got=%h exp=33334444", WBData_WB); end
    mem_m[8] = 32'h3333_4444;
  endtask

  task automatic test_random_ram();
    logic [31:0] a, d, exp_d;
    logic [4:0]  rw;
    logic        regw;
    int          op, idx;
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      st(32'(i) << 2, d);
      mem_m[i] = d;
    end
    for (int i = 0; i < 300; i++) begin
      op   = $urandom_range(0, 2);
      idx  = $urandom_range(0, 255);
      a    = (32'(idx) << 2) | 32'($urandom_range(0, 3));
      d    = $urandom;
      rw   = 5'($urandom_range(0, 31));
      regw = 1'($urandom_range(0, 1));
      if (op == 0) begin
        drive(0, 1, 0, regw, rw, a, d);
        mem_m[idx] = d;
        exp_d = a;
      end else if (op == 1) begin
        drive(1, 0, 1, regw, rw, a, 32'h0);
        exp_d = mem_m[idx];
      end else begin
        a = $urandom;
        drive(0, 0, 0, regw, rw, a, d);
        exp_d = a;
      end
      checks++; if (WBData_WB !== exp_d) begin errors++; $display("FAIL rand_op%0d_data got=%h exp=%h", op, WBData_WB, exp_d); end
      checks++; if (Rw_WB !== rw) begin errors++; $display("FAIL rand_rw got=%0d exp=%0d", Rw_WB, rw); end
      checks++; if (RegWrite_WB !== regw) begin errors++; $display("FAIL rand_regwrite got=%b exp=%b", RegWrite_WB, regw); end
    end
  endtask

  task automatic test_unmapped();
    st(32'h4000_000C, 32'hFFFF_FF5A);
    checks++; if (leds !== 8'h5A) begin errors++; $display("FAIL led_write got=%h exp=5a", leds); end
    ld(32'h4000_000C);
    checks++; if (WBData_WB !== 32'h0000_005A) begin errors++; $display("FAIL led_read got=%h exp=5a", WBData_WB); end
`ifdef MEM_TIMER_EN
    st(32'h4000_0000, 32'hCAFE_0001);
`endif
    drive(0, 0, 0, 0, 5'd0, 32'hFFFF_FFFF, 32'h0);
    ld(32'h8000_0000);
    checks++; if (WBData_WB !== 32'h0) begin errors++; $display("FAIL unmapped_read got=%h exp=0", WBData_WB); end
    st(32'h8000_0000, ~mem_m[0]);
    st(32'h8000_000C, 32'h0000_0011);
    ld(32'h0000_0000);
    checks++; if (WBData_WB !== mem_m[0]) begin errors++; $display("FAIL unmapped_ram got=%h exp=%h", WBData_WB, mem_m[0]); end
    checks++; if (leds !== 8'h5A) begin errors++; $display("FAIL unmapped_leds got=%h exp=5a", leds); end
`ifdef MEM_TIMER_EN
    ld(32'h4000_0000);
    checks++; if (WBData_WB !== 32'hCAFE_0001) begin errors++; $display("FAIL unmapped_th got=%h exp=cafe0001", WBData_WB); end
`endif
  endtask

`ifdef MEM_TIMER_EN
  task automatic test_timer_wrap();
    st(32'h4000_0008, 32'h0);
    st(32'h4000_0000, 32'hFFFF_FFF0);
    st(32'h4000_0004, 32'hFFFF_FFFE);
    st(32'h4000_0008, 32'h3);
    idle(2);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL wrap_irq got=%b exp=1", irq); end
    ld(32'h4000_0004);
    checks++; if (WBData_WB !== 32'hFFFF_FFF0) begin errors++; $display("FAIL wrap_tl got=%h exp=fffffff0", WBData_WB); end
    st(32'h4000_0008, 32'h3);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tcon_clear_irq got=%b exp=0", irq); end
    st(32'h4000_0004, 32'hFFFF_FFFF);
    st(32'h4000_0008, 32'h3);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL tcon_wrap_irq got=%b exp=1", irq); end
  endtask

  task automatic test_tl_write_wrap();
    st(32'h4000_0008, 32'h3);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tlw_pre_irq got=%b exp=0", irq); end
    st(32'h4000_0004, 32'hFFFF_FFFF);
    st(32'h4000_0004, 32'h0000_0100);
    ld(32'h4000_0004);
    checks++; if (WBData_WB !== 32'h0000_0100) begin errors++; $display("FAIL tlw_tl got=%h exp=100", WBData_WB); end
    ld(32'h4000_0008);
    checks++; if (WBData_WB !== 32'h7) begin errors++; $display("FAIL tlw_tcon got=%h exp=7", WBData_WB); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL tlw_irq got=%b exp=1", irq); end
  endtask

  task automatic test_timer_random();
    int          k, n;
    logic        ie;
    logic [31:0] th, exp_tl, exp_tcon;
    for (int it = 0; it < 10; it++) begin
      k  = $urandom_range(0, 5);
      n  = $urandom_range(0, 10);
      ie = 1'($urandom_range(0, 1));
      th = $urandom & 32'h7FFF_FFFF;
      st(32'h4000_0008, 32'h0);
      st(32'h4000_0000, th);
      st(32'h4000_0004, 32'hFFFF_FFFF - 32'(k));
      st(32'h4000_0008, {30'h0, ie, 1'b1});
      idle(n);
      checks++; if (irq !== (ie && (n > k))) begin errors++; $display("FAIL trand_irq k=%0d n=%0d got=%b exp=%b", k, n, irq, ie && (n > k)); end
      exp_tl = (n <= k) ? (32'hFFFF_FFFF - 32'(k) + 32'(n)) : (th + 32'(n - k - 1));
      ld(32'h4000_0004);
      checks++; if (WBData_WB !== exp_tl) begin errors++; $display("FAIL trand_tl k=%0d n=%0d got=%h exp=%h", k, n, WBData_WB, exp_tl); end
      exp_tcon = {29'h0, ie && (n + 1 > k), ie, 1'b1};
      ld(32'h4000_0008);
      checks++; if (WBData_WB !== exp_tcon) begin errors++; $display("FAIL trand_tcon k=%0d n=%0d got=%h exp=%h", k, n, WBData_WB, exp_tcon); end
    end
  endtask
`else
  task automatic test_no_timer();
    st(32'h4000_0000, 32'h1234_0000);
    st(32'h4000_0004, 32'hFFFF_FFFE);
    st(32'h4000_0008, 32'h7);
    drive(0, 0, 0, 0, 5'd0, 32'hFFFF_FFFF, 32'h0);
    ld(32'h4000_0000);
    checks++; if (WBData_WB !== 32'h0) begin errors++; $display("FAIL notimer_th got=%h exp=0", WBData_WB); end
    drive(0, 0, 0, 0, 5'd0, 32'hFFFF_FFFF, 32'h0);
    ld(32'h4000_0004);
    checks++; if (WBData_WB !== 32'h0) begin errors++; $display("FAIL notimer_tl got=%h exp=0", WBData_WB); end
    drive(0, 0, 0, 0, 5'd0, 32'hFFFF_FFFF, 32'h0);
    ld(32'h4000_0008);
    checks++; if (WBData_WB !== 32'h0) begin errors++; $display("FAIL notimer_tcon got=%h exp=0", WBData_WB); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL notimer_irq got=%b exp=0", irq); end
  endtask
`endif

  task automatic test_reset_mid_store();
    st(32'h0000_0040, 32'h0BAD_F00D);
    mem_m[16] = 32'h0BAD_F00D;
    st(32'h4000_000C, 32'h0000_00AA);
    checks++; if (leds !== 8'hAA) begin errors++; $display("FAIL mid_leds_pre got=%h exp=aa", leds); end
`ifdef MEM_TIMER_EN
    st(32'h4000_0000, 32'h0);
    st(32'h4000_0004, 32'hFFFF_FFFF);
    st(32'h4000_0008, 32'h3);
    idle(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mid_irq_pre got=%b exp=1", irq); end
`endif
    MemWrite_MEM = 1; RegWrite_MEM = 1; Rw_MEM = 5'd3;
    ALUOut_MEM = 32'h0000_0040; WriteData_MEM = 32'h5555_AAAA;
    #2 reset = 1;
    #1;
    checks++; if (WBData_WB !== 32'h0) begin errors++; $display("FAIL mid_wbdata got=%h exp=0", WBData_WB); end
    checks++; if (Rw_WB !== 5'd0) begin errors++; $display("FAIL mid_rw got=%0d exp=0", Rw_WB); end
    checks++; if (RegWrite_WB !== 1'b0) begin errors++; $display("FAIL mid_regwrite got=%b exp=0", RegWrite_WB); end
    checks++; if (leds !== 8'h00) begin errors++; $display("FAIL mid_leds got=%h exp=0", leds); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq got=%b exp=0", irq); end
    @(posedge clk); #1;
    set_idle();
    reset = 0;
    ld(32'h0000_0040);
    checks++; if (WBData_WB !== 32'h0BAD_F00D) begin errors++; $display("FAIL mid_ram got=%h exp=0badf00d", WBData_WB); end
    ld(32'h4000_0004);
    checks++; if (WBData_WB !== 32'h0) begin errors++; $display("FAIL mid_tl got=%h exp=0", WBData_WB); end
  endtask

  initial begin
    set_idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 0;
    test_store_load();
    test_passthrough();
    test_same_addr_rw();
    test_random_ram();
    test_unmapped();
`ifdef MEM_TIMER_EN
    test_timer_wrap();
    test_tl_write_wrap();
    test_timer_random();
`else
    test_no_timer();
`endif
    test_reset_mid_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
